// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_responder
//  Description : Slave side of the core data_sram port. Word-organised RAM
//                with byte write enables plus a 16-byte MMIO window holding
//                LED, free-running timer, compare/interrupt and scratch regs.
//                All reads return through one register, one cycle after issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        timer_int
);

    localparam int         c_DEPTH    = 2 ** ADDR_W;
    localparam logic [1:0] c_OFF_LED  = 2'd0;
    localparam logic [1:0] c_OFF_TMR  = 2'd1;
    localparam logic [1:0] c_OFF_CMP  = 2'd2;
    localparam logic [1:0] c_OFF_SCR  = 2'd3;

    logic [31:0] r_mem [0:c_DEPTH-1];
    logic [31:0] r_rdata;
    logic [31:0] r_led;
    logic [31:0] r_timer;
    logic [31:0] r_compare;
    logic [31:0] r_scratch;
    logic        r_timer_int;

    logic              w_is_mmio;
    logic [1:0]        w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_wr;
    logic              w_ram_wr;
    logic              w_mmio_wr;
    logic [31:0]       w_mmio_rd;
    logic              w_unused_bits;

    // Merge new write data into an existing word, lane by lane.
    function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
        f_merge = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) f_merge[8*i +: 8] = new_w[8*i +: 8];
        end
    endfunction

    // Address decode; RAM index drops high bits so the RAM aliases across space.
    always_comb begin
        w_is_mmio     = (data_sram_addr[31:4] == MMIO_BASE[31:4]);
        w_off         = data_sram_addr[3:2];
        w_idx         = data_sram_addr[ADDR_W+1:2];
        w_wr          = data_sram_en && (data_sram_wen != 4'b0000);
        w_ram_wr      = w_wr && !w_is_mmio;
        w_mmio_wr     = w_wr && w_is_mmio;
        w_unused_bits = ^data_sram_addr[1:0];
    end

    // MMIO read mux; timer value is the one before this edge's increment.
    always_comb begin
        w_mmio_rd = 32'h0;
        case (w_off)
            c_OFF_LED: w_mmio_rd = r_led;
            c_OFF_TMR: w_mmio_rd = r_timer;
            c_OFF_CMP: w_mmio_rd = r_compare;
            c_OFF_SCR: w_mmio_rd = r_scratch;
            default:   w_mmio_rd = 32'h0;
        endcase
    end

    // RAM byte-lane writes; contents survive reset but reset blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Read-data register: read-first on every access, holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (data_sram_en) begin
            r_rdata <= w_is_mmio ? w_mmio_rd : r_mem[w_idx];
        end
    end

    // LED, compare and scratch registers with per-lane writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= 32'h0;
            r_compare <= 32'hFFFF_FFFF;
            r_scratch <= 32'h0;
        end else if (w_mmio_wr) begin
            if (w_off == c_OFF_LED) r_led     <= f_merge(r_led,     data_sram_wdata, data_sram_wen);
            if (w_off == c_OFF_CMP) r_compare <= f_merge(r_compare, data_sram_wdata, data_sram_wen);
            if (w_off == c_OFF_SCR) r_scratch <= f_merge(r_scratch, data_sram_wdata, data_sram_wen);
        end
    end

    // Free-running timer; a write loads instead of incrementing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= 32'h0;
        end else if (w_mmio_wr && (w_off == c_OFF_TMR)) begin
            r_timer <= f_merge(r_timer, data_sram_wdata, data_sram_wen);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Sticky compare flag; a compare write clears it and beats a same-cycle match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer_int <= 1'b0;
        end else if (w_mmio_wr && (w_off == c_OFF_CMP)) begin
            r_timer_int <= 1'b0;
        end else if (r_timer == r_compare) begin
            r_timer_int <= 1'b1;
        end
    end

    assign data_sram_rdata = r_rdata;
    assign led             = r_led[15:0];
    assign timer_int       = r_timer_int;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_responder
//  Description : Directed self-checking bench for data_sram_responder.
//                Inputs change on the falling edge; outputs are sampled on the
//                falling edge after the rising edge that consumed the access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

    localparam logic [31:0] c_LED = 32'hBFAF_F000;
    localparam logic [31:0] c_TMR = 32'hBFAF_F004;
    localparam logic [31:0] c_CMP = 32'hBFAF_F008;
    localparam logic [31:0] c_SCR = 32'hBFAF_F00C;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        timer_int;

    int n_vec;
    int n_err;

    data_sram_responder #(
        .ADDR_W    (16),
        .MMIO_BASE (32'hBFAF_F000)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .timer_int       (timer_int)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one access for exactly one rising edge, return at the next falling edge.
    task automatic access(input logic e, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        en    = 1'b0;
        wen   = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        access(1'b1, w, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        access(1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic idle();
        access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        en    = 1'b0;
        wen   = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("rst_rdata", rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_int", {31'h0, timer_int}, 32'h0);
        rd(c_CMP);
        check("rst_compare", rdata, 32'hFFFF_FFFF);
        rd(c_SCR);
        check("rst_scratch", rdata, 32'h0);

        // 1: full-word write then read.
        wr(32'h0000_0010, 4'hF, 32'h1234_5678);
        rd(32'h0000_0010);
        check("ram_word", rdata, 32'h1234_5678);

        // 2: partial byte write, with read-first data on the write cycle.
        wr(32'h0000_0020, 4'hF, 32'hAABB_CCDD);
        wr(32'h0000_0020, 4'b0010, 32'h0000_EE00);
        check("read_first", rdata, 32'hAABB_CCDD);
        rd(32'h0000_0020);
        check("byte_lane", rdata, 32'hAABB_EEDD);

        // 3: address aliasing above the RAM index bits.
        wr(32'h0000_0004, 4'hF, 32'hCAFE_F00D);
        rd(32'h0004_0004);
        check("alias", rdata, 32'hCAFE_F00D);

        // 4: timer load and wrap; the FFFF_FFFF pass matches reset compare.
        wr(c_TMR, 4'hF, 32'hFFFF_FFFE);
        rd(c_TMR);
        check("tmr_load", rdata, 32'hFFFF_FFFE);
        rd(c_TMR);
        check("tmr_max", rdata, 32'hFFFF_FFFF);
        rd(c_TMR);
        check("tmr_wrap", rdata, 32'h0000_0000);
        check("int_at_max", {31'h0, timer_int}, 32'h1);

        // 5a: compare=5 after timer=0; flag rises on the edge the timer reads 5.
        wr(c_TMR, 4'hF, 32'h0);
        wr(c_CMP, 4'hF, 32'h5);
        check("int_cleared", {31'h0, timer_int}, 32'h0);
        rd(c_TMR);
        rd(c_TMR);
        rd(c_TMR);
        rd(c_TMR);
        check("tmr_4", rdata, 32'h4);
        check("int_before", {31'h0, timer_int}, 32'h0);
        rd(c_TMR);
        check("tmr_5", rdata, 32'h5);
        check("int_set", {31'h0, timer_int}, 32'h1);
        idle();
        idle();
        check("rdata_hold", rdata, 32'h5);
        check("int_sticky", {31'h0, timer_int}, 32'h1);

        // 5b: compare write in the exact matching cycle keeps the flag low.
        wr(c_TMR, 4'hF, 32'h0);
        wr(c_CMP, 4'hF, 32'h5);
        check("int_clr2", {31'h0, timer_int}, 32'h0);
        idle();
        idle();
        idle();
        idle();
        wr(c_CMP, 4'hF, 32'h5);
        check("int_clr_wins", {31'h0, timer_int}, 32'h0);
        idle();
        check("int_after", {31'h0, timer_int}, 32'h0);

        // LED and scratch with lane enables.
        wr(c_LED, 4'hF, 32'h0000_A5A5);
        check("led_out", {16'h0, led}, 32'h0000_A5A5);
        rd(c_LED);
        check("led_read", rdata, 32'h0000_A5A5);
        wr(c_SCR, 4'b1001, 32'h1122_3344);
        rd(c_SCR);
        check("scratch_lanes", rdata, 32'h1100_0044);

        // 6: reset in the middle of LED traffic; RAM keeps its contents.
        wr(c_LED, 4'hF, 32'h0000_1234);
        rst = 1'b1;
        wr(c_LED, 4'hF, 32'h0000_FFFF);
        check("rst_led_mid", {16'h0, led}, 32'h0);
        rd(c_LED);
        check("rst_rdata_mid", rdata, 32'h0);
        rst = 1'b0;
        rd(32'h0000_0010);
        check("ram_kept", rdata, 32'h1234_5678);
        rd(c_CMP);
        check("cmp_after_rst", rdata, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
